// File: rtl/sgmii_an_cfg_rx.sv
// SGMII receive auto-negotiation parser: finds /C/ and /I/ ordered sets,
// qualifies the link-partner config word and exposes its SGMII fields.
module sgmii_an_cfg_rx #(
  parameter int MATCH_COUNT = 3,
  parameter int CNT_W       = 4
) (
  input  logic        sgmii_clk_in,
  input  logic        reset_n,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  input  logic        rx_is_k,
  input  logic        rx_code_err,
  output logic        cfg_valid,
  output logic [15:0] cfg_word,
  output logic        ability_match,
  output logic        ack_match,
  output logic        idle_match,
  output logic        restart_seen,
  output logic        lp_link,
  output logic        lp_duplex,
  output logic [1:0]  lp_speed
);

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    COMMA  = 2'd1,
    CFG_LO = 2'd2,
    CFG_HI = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] MATCH_TH = CNT_W'(MATCH_COUNT);
  localparam logic [15:0]      ACK_MASK = 16'hBFFF;

  state_t           state_r;
  logic [7:0]       lo_r;
  logic [15:0]      prev_r;
  logic [CNT_W-1:0] cfg_cnt_r;
  logic [CNT_W-1:0] idle_cnt_r;

  logic             comma_s;
  logic             cfg_start_s;
  logic             idle_end_s;
  logic [15:0]      new_word_s;
  logic             new_run_s;
  logic [CNT_W-1:0] cfg_cnt_nxt_s;
  logic [CNT_W-1:0] idle_cnt_nxt_s;
  logic             ability_nxt_s;

  assign comma_s     = rx_is_k && (rx_data == 8'hBC);
  assign cfg_start_s = !rx_is_k && ((rx_data == 8'hB5) || (rx_data == 8'h42));
  assign idle_end_s  = !rx_is_k && ((rx_data == 8'hC5) || (rx_data == 8'h50));
  assign new_word_s  = {rx_data, lo_r};
  // Bit 14 (ack) is ignored when deciding whether two words belong to the same run.
  assign new_run_s   = (cfg_cnt_r == CNT_ZERO) ||
                       ((new_word_s & ACK_MASK) != (prev_r & ACK_MASK));

  // Next values of both match counters for a set completing this cycle.
  always_comb begin
    cfg_cnt_nxt_s  = CNT_ZERO;
    idle_cnt_nxt_s = CNT_ZERO;
    if (new_run_s) begin
      cfg_cnt_nxt_s = CNT_ONE;
    end else if (cfg_cnt_r == CNT_MAX) begin
      cfg_cnt_nxt_s = CNT_MAX;
    end else begin
      cfg_cnt_nxt_s = cfg_cnt_r + CNT_ONE;
    end
    if (idle_cnt_r == CNT_MAX) begin
      idle_cnt_nxt_s = CNT_MAX;
    end else begin
      idle_cnt_nxt_s = idle_cnt_r + CNT_ONE;
    end
    ability_nxt_s = (cfg_cnt_nxt_s >= MATCH_TH);
  end

  // Ordered-set FSM, match counters and all registered outputs.
  always_ff @(posedge sgmii_clk_in) begin
    if (!reset_n) begin
      state_r       <= HUNT;
      lo_r          <= 8'h00;
      prev_r        <= 16'h0000;
      cfg_cnt_r     <= CNT_ZERO;
      idle_cnt_r    <= CNT_ZERO;
      cfg_valid     <= 1'b0;
      cfg_word      <= 16'h0000;
      ability_match <= 1'b0;
      ack_match     <= 1'b0;
      idle_match    <= 1'b0;
      restart_seen  <= 1'b0;
      lp_link       <= 1'b0;
      lp_duplex     <= 1'b0;
      lp_speed      <= 2'b00;
    end else if (!rx_valid) begin
      cfg_valid    <= 1'b0;
      restart_seen <= 1'b0;
    end else if (rx_code_err) begin
      state_r       <= HUNT;
      cfg_cnt_r     <= CNT_ZERO;
      idle_cnt_r    <= CNT_ZERO;
      cfg_valid     <= 1'b0;
      restart_seen  <= 1'b0;
      ability_match <= 1'b0;
      ack_match     <= 1'b0;
      idle_match    <= 1'b0;
    end else begin
      cfg_valid    <= 1'b0;
      restart_seen <= 1'b0;
      case (state_r)
        HUNT: begin
          state_r <= comma_s ? COMMA : HUNT;
        end
        COMMA: begin
          if (comma_s) begin
            state_r <= COMMA;
          end else if (cfg_start_s) begin
            state_r <= CFG_LO;
          end else if (idle_end_s) begin
            state_r       <= HUNT;
            idle_cnt_r    <= idle_cnt_nxt_s;
            idle_match    <= (idle_cnt_nxt_s >= MATCH_TH);
            cfg_cnt_r     <= CNT_ZERO;
            ability_match <= 1'b0;
            ack_match     <= 1'b0;
          end else begin
            state_r <= HUNT;
          end
        end
        CFG_LO: begin
          if (comma_s) begin
            state_r <= COMMA;
          end else begin
            lo_r    <= rx_data;
            state_r <= CFG_HI;
          end
        end
        CFG_HI: begin
          if (comma_s) begin
            state_r <= COMMA;
          end else begin
            state_r       <= HUNT;
            cfg_valid     <= 1'b1;
            cfg_word      <= new_word_s;
            cfg_cnt_r     <= cfg_cnt_nxt_s;
            prev_r        <= new_run_s ? new_word_s : prev_r;
            idle_cnt_r    <= CNT_ZERO;
            idle_match    <= 1'b0;
            ability_match <= ability_nxt_s;
            ack_match     <= ability_nxt_s && rx_data[6];
            restart_seen  <= ability_nxt_s && !ability_match && (new_word_s == 16'h0000);
            if (ability_nxt_s) begin
              lp_link   <= rx_data[7];
              lp_duplex <= rx_data[4];
              lp_speed  <= rx_data[3:2];
            end else begin
              lp_link   <= lp_link;
              lp_duplex <= lp_duplex;
              lp_speed  <= lp_speed;
            end
          end
        end
        default: begin
          state_r <= HUNT;
        end
      endcase
    end
  end

endmodule

// File: doc/sgmii_an_cfg_rx.md
Name: sgmii_an_cfg_rx

Overview:
- Receive-side auto-negotiation stage that consumes the decoded 8b/10b code-group stream from the SGMII deserializer/decoder.
- Recognises /C1/, /C2/ configuration ordered sets and /I1/, /I2/ idle ordered sets, and extracts the 16-bit link-partner config word.
- Qualifies the config word by consecutive matching and exposes the SGMII fields (link, duplex, speed, ack) to the auto-negotiation control FSM in entry_point.
- It is the direct consumer of what the /C/ ordered-set transmitter stage generates on the wire.

Parameters:
- MATCH_COUNT, 3, number of consecutive identical /C/ words (or /I/ sets) required before a match is asserted; legal range 1..15.
- CNT_W, 4, width of the internal match counters.

Ports:
- sgmii_clk_in  in  1  125 MHz code-group clock; all logic is on its rising edge.
- reset_n  in  1  synchronous, active-low reset.
- rx_valid  in  1  the code group on rx_data/rx_is_k is valid this cycle.
- rx_data  in  8  decoded code-group byte.
- rx_is_k  in  1  1 = control (K) code group.
- rx_code_err  in  1  invalid code group or running-disparity error this cycle.
- cfg_valid  out  1  one-cycle pulse when a complete /C/ set is received.
- cfg_word  out  16  last complete config word, {cfg_hi, cfg_lo}.
- ability_match  out  1  MATCH_COUNT consecutive identical words, compared with bit 14 masked.
- ack_match  out  1  ability_match is set and bit 14 of cfg_word is 1.
- idle_match  out  1  MATCH_COUNT consecutive /I/ sets received.
- restart_seen  out  1  one-cycle pulse when ability_match is reached on word 0x0000.
- lp_link  out  1  cfg_word[15], registered when ability_match rises.
- lp_duplex  out  1  cfg_word[12], registered when ability_match rises.
- lp_speed  out  2  cfg_word[11:10], registered when ability_match rises.

Behaviour:
- Reset (reset_n = 0 at a clock edge): every output is 0, the FSM is in HUNT, and both counters are 0.
- Reset asserted mid-set: the partial set is discarded. Reset takes priority over all other inputs.
- rx_valid = 0: FSM, counters and outputs hold. cfg_valid and restart_seen are forced to 0 that cycle.
- Comma: rx_is_k = 1 and rx_data = 0xBC (K28.5).
- FSM states and transitions:
  - HUNT: comma -> COMMA. Anything else -> stay in HUNT.
  - COMMA: the byte after the comma must be a D code group.
    - 0xB5 (D21.5) or 0x42 (D2.2) -> CFG_LO.
    - 0xC5 (D5.6) or 0x50 (D16.2) -> idle set complete; go to HUNT.
    - Comma -> stay in COMMA (re-sync).
    - Any other byte -> HUNT, counters untouched.
  - CFG_LO: latch the byte into lo_reg -> CFG_HI.
  - CFG_HI: latch the byte; on the next cycle cfg_valid = 1 and cfg_word = {byte, lo_reg} -> HUNT.
- Latency: cfg_valid and cfg_word update 1 cycle after the cfg_hi byte is sampled. ability_match updates in that same cycle.
- A comma arriving in CFG_LO or CFG_HI aborts the set with no cfg_valid and moves the FSM to COMMA. The match counters are not cleared.
- Data bytes in CFG_LO/CFG_HI are not checked for K; a K byte other than a comma is accepted as data.
- rx_code_err = 1 with rx_valid = 1, in any state:
  - abort any partial set and go to HUNT;
  - clear both counters;
  - deassert ability_match, ack_match and idle_match on the next cycle.
- Config counter, on each completed /C/ set:
  - count 0, or (new word & 0xBFFF) != (prev word & 0xBFFF) -> count = 1 and prev = new word;
  - equal -> count + 1, saturating at 2^CNT_W - 1.
  - ability_match = (count >= MATCH_COUNT).
  - ack_match additionally requires bit 14 of the latest word to be 1.
- Idle counter: increments, saturating, on each completed /I/ set. idle_match = (idle count >= MATCH_COUNT).
- A completed /I/ set clears the config counter. A completed /C/ set clears the idle counter.
- Link-partner fields: lp_link, lp_duplex and lp_speed load from cfg_word on the cycle ability_match goes 0->1. They also reload while ability_match is held and a new matching word arrives. They are unchanged when ability_match falls.
- restart_seen pulses on the same cycle ability_match rises, when the matched word is 0x0000.
- With MATCH_COUNT = 1, ability_match rises together with the first cfg_valid.

Test Plan:
- Reset: hold reset_n = 0 for 5 cycles while driving valid /C1/ sets -> all outputs remain 0.
- Ability match: send /C1/ /C2/ /C1/ with word 0x9801 -> cfg_valid pulses 3 times; ability_match rises 1 cycle after the 3rd cfg_hi byte; lp_link = 1, lp_duplex = 1, lp_speed = 2'b10, ack_match = 0. Then send 0xD801 -> ack_match = 1 and ability_match stays 1.
- Mismatch and abort:
  - send 0x9801, 0x9801, 0x9401 -> ability_match stays 0; 2 further 0x9401 sets -> it rises with lp_speed = 2'b01;
  - inject a comma in CFG_HI -> no cfg_valid, and the following set parses correctly.
- Code error: while ability_match = 1, pulse rx_code_err for one cycle -> ability_match = 0 on the next cycle; 3 more /C/ sets are needed to re-assert it.
- Idle and restart:
  - 3 × /I2/ (BC 50) -> idle_match = 1; one /C1/ set -> idle_match = 0;
  - 3 × word 0x0000 -> restart_seen pulses exactly once.
- Stall: rx_valid low for 4 cycles between cfg_lo and cfg_hi -> cfg_word is still correct, with exactly one cfg_valid pulse.
